// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port 256x32 word RAM with byte-strobe writes done as read-modify-write.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_valid,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_ren,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        MERGE
    } state_t;

    state_t                  state_q;
    logic                    grant_q;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;

    logic                    ramRen_q;
    logic                    ramWen_q;
    logic [ADDR_WIDTH-1:0]   ramRaddr_q;
    logic [ADDR_WIDTH-1:0]   ramWaddr_q;
    logic [DATA_WIDTH-1:0]   ramWdata_q;
    logic                    m0Ready_q;
    logic                    m1Ready_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic                    lastGrant_q;
`endif

    logic                    anyValid;
    logic                    grant_d;
    logic [ADDR_WIDTH-1:0]   index_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [3:0]              wstrb_d;
    logic [DATA_WIDTH-1:0]   mergedWord;

    // Only the word index is used; the byte offset and high bits alias.
    logic unused_addrBits;
    assign unused_addrBits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                               m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

    assign anyValid = m0_valid | m1_valid;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_valid && m1_valid) begin
            grant_d = ~lastGrant_q;
        end else begin
            grant_d = ~m0_valid;
        end
`else
        grant_d = ~m0_valid;
`endif
        index_d = grant_d ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
        wdata_d = grant_d ? m1_wdata : m0_wdata;
        wstrb_d = grant_d ? m1_wstrb : m0_wstrb;
    end

    // The old word arrives from the RAM in the MERGE cycle, so the merge stays combinational.
    always_comb begin
        mergedWord = ram_rdata;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (wstrb_q[i]) begin
                mergedWord[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ramRen_q   <= 1'b0;
            ramWen_q   <= 1'b0;
            ramRaddr_q <= '0;
            ramWaddr_q <= '0;
            ramWdata_q <= '0;
            m0Ready_q  <= 1'b0;
            m1Ready_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant_q <= 1'b1;
`endif
        end else begin
            ramRen_q   <= 1'b0;
            ramWen_q   <= 1'b0;
            ramRaddr_q <= '0;
            ramWaddr_q <= '0;
            ramWdata_q <= '0;
            m0Ready_q  <= 1'b0;
            m1Ready_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (anyValid) begin
                        grant_q <= grant_d;
                        index_q <= index_d;
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
`ifdef ARB_ROUND_ROBIN_EN
                        lastGrant_q <= grant_d;
`endif
                        state_q <= ACCESS;
                        if (wstrb_d == 4'hF) begin
                            ramWen_q   <= 1'b1;
                            ramWaddr_q <= index_d;
                            ramWdata_q <= wdata_d;
                            m0Ready_q  <= ~grant_d;
                            m1Ready_q  <= grant_d;
                        end else begin
                            ramRen_q   <= 1'b1;
                            ramRaddr_q <= index_d;
                        end
                    end
                end

                ACCESS: begin
                    if (wstrb_q == 4'hF) begin
                        state_q <= IDLE;
                    end else if (wstrb_q == 4'h0) begin
                        state_q   <= RDATA;
                        m0Ready_q <= ~grant_q;
                        m1Ready_q <= grant_q;
                    end else begin
                        state_q    <= MERGE;
                        ramWen_q   <= 1'b1;
                        ramWaddr_q <= index_q;
                        m0Ready_q  <= ~grant_q;
                        m1Ready_q  <= grant_q;
                    end
                end

                RDATA:   state_q <= IDLE;
                MERGE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_ren   = ramRen_q;
    assign ram_wen   = ramWen_q;
    assign ram_raddr = ramRaddr_q;
    assign ram_waddr = ramWaddr_q;
    assign ram_wdata = (state_q == MERGE) ? mergedWord : ramWdata_q;
    assign m0_ready  = m0Ready_q;
    assign m1_ready  = m1Ready_q;
    assign m0_rdata  = (state_q == RDATA && !grant_q) ? ram_rdata : '0;
    assign m1_rdata  = (state_q == RDATA &&  grant_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter with a behavioural 256x32 RAM.
// Expectations follow ARB_ROUND_ROBIN_EN when the arbitration sequence is checked.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ren, ram_wen;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    int errors = 0;
    int checks = 0;
    int rdyCount [2];
    int doneCount [2];
    int exclErrors = 0;
    int rwErrors = 0;
    int rdataErrors = 0;
    logic [7:0] lastRaddr;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        ram_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    // Protocol monitor, sampled on the falling edge.
    initial begin
        rdyCount[0] = 0;
        rdyCount[1] = 0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_ready && m1_ready) exclErrors++;
            if (ram_ren && ram_wen) rwErrors++;
            if (!m0_ready && m0_rdata != 32'h0) rdataErrors++;
            if (!m1_ready && m1_rdata != 32'h0) rdataErrors++;
            if (m0_ready) rdyCount[0]++;
            if (m1_ready) rdyCount[1]++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = newW[8*b +: 8];
        end
        return r;
    endfunction

    // One transaction on master m; lat counts cycles from the IDLE sample cycle to ready.
    task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata, output int lat);
        bit got;
        bit rdy;
        got   = 0;
        rdata = 32'h0;
        lat   = -1;
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb;
        end else begin
            m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (ram_ren) lastRaddr = ram_raddr;
            rdy = (m == 0) ? m0_ready : m1_ready;
            if (rdy) begin
                got   = 1;
                lat   = i;
                rdata = (m == 0) ? m0_rdata : m1_rdata;
            end
        end
        if (!got) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
        if (got) doneCount[m]++;
    endtask

    task automatic randomTraffic(input int m);
        logic [31:0] rd, addr, wd;
        logic [3:0]  strb;
        int          lat, word, kind;
        for (int n = 0; n < 25; n++) begin
            word = (m == 0) ? 16 + $urandom_range(15) : 32 + $urandom_range(15);
            addr = ($urandom() & 32'hFFFF_FC03) | (32'(word) << 2);
            kind = $urandom_range(2);
            wd   = $urandom();
            strb = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
            applyStimulus(m, addr, wd, strb, rd, lat);
            if (strb == 4'h0) checkOutput("rand_read", rd, shadow[word]);
            else              shadow[word] = mergeWord(shadow[word], wd, strb);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          who[$];
        int          when[$];
        int          expWho;
        int          base0, base1, done0, done1;
        bit          found;

        doneCount[0] = 0;
        doneCount[1] = 0;
        reset = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        checkOutput("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        checkOutput("rst_ram_ren", {31'b0, ram_ren}, 32'd0);
        checkOutput("rst_ram_wen", {31'b0, ram_wen}, 32'd0);
        checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
        checkOutput("rst_addrs", {16'b0, ram_raddr, ram_waddr}, 32'd0);
        reset = 1'b0;

        applyStimulus(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        checkOutput("m0_fullwr_lat", lat, 32'd1);
        checkOutput("m0_fullwr_mem", mem[4], 32'hDEADBEEF);
        applyStimulus(0, 32'h10, 32'h0, 4'h0, rd, lat);
        checkOutput("m0_rd_lat", lat, 32'd2);
        checkOutput("m0_rd_data", rd, 32'hDEADBEEF);

        applyStimulus(1, 32'h10, 32'h000000AA, 4'b0001, rd, lat);
        checkOutput("m1_partwr_lat", lat, 32'd2);
        applyStimulus(1, 32'h10, 32'h0, 4'h0, rd, lat);
        checkOutput("m1_partwr_readback", rd, 32'hDEADBEAA);
        applyStimulus(1, 32'h10, 32'h11223344, 4'b1010, rd, lat);
        applyStimulus(0, 32'h10, 32'h0, 4'h0, rd, lat);
        checkOutput("m1_partwr2_readback", rd, 32'h11AD33AA);

        applyStimulus(0, 32'h0, 32'hCAFEF00D, 4'hF, rd, lat);
        applyStimulus(1, 32'h400, 32'h0, 4'h0, rd, lat);
        checkOutput("alias_raddr", {24'b0, lastRaddr}, 32'd0);
        checkOutput("alias_data", rd, 32'hCAFEF00D);
        applyStimulus(1, 32'hFFFF_FC13, 32'h0, 4'h0, rd, lat);
        checkOutput("alias_hi_raddr", {24'b0, lastRaddr}, 32'd4);
        checkOutput("alias_hi_data", rd, 32'h11AD33AA);

        // Both masters request reads continuously; the last grant above went to m1.
        @(posedge clk);
        #1;
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0;  m1_wstrb = 4'h0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m0_ready) begin
                who.push_back(0);
                when.push_back(i);
                checkOutput("arb_m0_rdata", m0_rdata, 32'h11AD33AA);
            end
            if (m1_ready) begin
                who.push_back(1);
                when.push_back(i);
                checkOutput("arb_m1_rdata", m1_rdata, 32'hCAFEF00D);
            end
        end
        @(posedge clk);
        #1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        checkOutput("arb_count", who.size(), 32'd5);
        for (int k = 0; k < who.size() && k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            expWho = k % 2;
`else
            expWho = 0;
`endif
            checkOutput("arb_who", who[k], expWho);
            checkOutput("arb_cycle", when[k], 2 + 3 * k);
        end
        repeat (3) @(posedge clk);

        applyStimulus(0, 32'h20, 32'h12345678, 4'hF, rd, lat);
        @(posedge clk);
        #1;
        m0_valid = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h000000FF; m0_wstrb = 4'b0001;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ram_wen) found = 1;
        end
        checkOutput("midop_merge_seen", {31'b0, found}, 32'd1);
        #1;
        reset = 1'b1;
        m0_valid = 1'b0;
        #1;
        checkOutput("midop_m0_ready", {31'b0, m0_ready}, 32'd0);
        checkOutput("midop_ram_wen", {31'b0, ram_wen}, 32'd0);
        checkOutput("midop_ram_ren", {31'b0, ram_ren}, 32'd0);
        checkOutput("midop_ram_wdata", ram_wdata, 32'd0);
        checkOutput("midop_ram_waddr", {24'b0, ram_waddr}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midop_ram_kept", mem[8], 32'h12345678);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 32'h20, 32'h0, 4'h0, rd, lat);
        checkOutput("post_rst_lat", lat, 32'd2);
        checkOutput("post_rst_data", rd, 32'h12345678);

        repeat (2) @(posedge clk);
        base0 = rdyCount[0];
        base1 = rdyCount[1];
        done0 = doneCount[0];
        done1 = doneCount[1];
        fork
            randomTraffic(0);
            randomTraffic(1);
        join
        repeat (4) @(posedge clk);
        checkOutput("rand_m0_one_ready", rdyCount[0] - base0, doneCount[0] - done0);
        checkOutput("rand_m1_one_ready", rdyCount[1] - base1, doneCount[1] - done1);
        checkOutput("rand_m0_done", doneCount[0] - done0, 32'd25);
        checkOutput("rand_m1_done", doneCount[1] - done1, 32'd25);
        checkOutput("ready_exclusive", exclErrors, 32'd0);
        checkOutput("ren_wen_exclusive", rwErrors, 32'd0);
        checkOutput("idle_rdata_zero", rdataErrors, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous word RAM (256x32, 1-cycle registered read, whole-word write enable) between two requesters on picorv32-native-style valid/ready buses.
- m0 is the CPU data/instruction port; m1 is the bootloader loader port.
- Sequences every access and implements byte-strobe writes as read-modify-write, because the RAM has whole-word write only.
- Sits between the core/loader and the RAM instance in the SoC top.

Parameters:
- ADDR_WIDTH, 8: RAM word-address width; word index = mX_addr[ADDR_WIDTH+1:2].
- DATA_WIDTH, 32: data width; fixed at 32 (4 byte lanes).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- m0_valid  input  1  CPU request
- m0_addr  input  32  CPU byte address
- m0_wdata  input  32  CPU write data
- m0_wstrb  input  4  CPU byte strobes; 0 = read
- m0_ready  output  1  CPU completion pulse
- m0_rdata  output  32  CPU read data; valid only while m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same widths and meanings as m0, for the loader
- ram_ren  output  1  RAM read enable
- ram_wen  output  1  RAM write enable
- ram_raddr  output  ADDR_WIDTH  RAM read word address
- ram_waddr  output  ADDR_WIDTH  RAM write word address
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM registered read data

Behaviour:
- States: IDLE, ACCESS, RDATA, MERGE.
- Reset (async, any state): state=IDLE, grant=m0, last_grant=m1. ram_ren, ram_wen, m0_ready, m1_ready all 0; ram_raddr, ram_waddr, ram_wdata = 0. An in-flight transaction is aborted with no ready pulse, and no RAM write occurs after reset asserts.
- IDLE:
  - No valid request: stay in IDLE.
  - Otherwise latch grant, addr word index, wdata and wstrb from the chosen master, then go to ACCESS.
  - Choice: only one master valid → that master. Both valid → arbitration policy (see Optional Feature).
- ACCESS:
  - wstrb==0: ram_ren=1, ram_raddr=index → RDATA.
  - wstrb==4'hF: ram_wen=1, ram_waddr=index, ram_wdata=wdata; granted ready=1 this cycle → IDLE.
  - Any other wstrb: ram_ren=1, ram_raddr=index → MERGE.
- RDATA: granted ready=1; granted rdata=ram_rdata → IDLE.
- MERGE: ram_wen=1, ram_waddr=index, ram_wdata = per byte lane i: wstrb[i] ? wdata byte i : ram_rdata byte i. Granted ready=1 → IDLE.
- Latency, with valid sampled in IDLE at cycle 0:
  - full-word write: ready at cycle 1
  - read: ready at cycle 2
  - partial write: ready at cycle 2
- Back-to-back: a new grant decision is made only in IDLE, so there is one IDLE cycle between transactions. Peak throughput is one read per 3 cycles.
- ready is a single-cycle pulse, and only the granted master's ready is ever asserted. m0_ready and m1_ready are never high together.
- Non-granted rdata outputs are 0.
- Masters hold valid, addr, wdata and wstrb stable until ready; the arbiter uses latched copies.
- A master that drops valid mid-transaction does not abort it: the access completes and the ready pulse is still issued.
- Address bits above ADDR_WIDTH+1 and bits [1:0] are ignored, so addresses alias modulo 4*2^ADDR_WIDTH bytes.
- ram_ren and ram_wen are never high in the same cycle.
- RAM-side outputs are 0 in every state other than those listed above.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both masters are valid in IDLE, grant the master not equal to last_grant. last_grant updates on every grant.
- Undefined: fixed priority, m0 always wins ties; m1 is served only when m0_valid=0 in IDLE. last_grant logic is not compiled.

Test Plan:
- Reset mid-op: assert reset during MERGE of a partial write → all outputs 0 immediately, no ready pulse, target RAM word unchanged, state IDLE.
- m0 full write then read: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF → m0_ready at cycle 1, RAM word 4 written. Read 0x10 → m0_ready at cycle 2 with m0_rdata=0xDEADBEEF.
- Partial write: word 4 = 0xDEADBEEF; m1 writes 0x000000AA with wstrb 4'b0001 → ready at cycle 2; readback 0xDEADBEAA.
- Both masters valid reads every cycle, with ARB_ROUND_ROBIN_EN → grants alternate m0, m1, m0, m1 with 3-cycle spacing; without the macro → m1 never granted while m0_valid stays high.
- Alias: read 0x400 with ADDR_WIDTH=8 → ram_raddr=0, same data as address 0x0.
- Mutual exclusion: random traffic on both ports → m0_ready and m1_ready never high together, ram_ren and ram_wen never high together, every valid eventually gets exactly one ready.
